// File: rtl/dsp_frame_gen.sv
// dsp_frame_gen: radar PRI/CPI timing generator and ADC sample gater feeding dsp_top.
// Define DSP_FRAME_TEST_PATTERN_EN to add the gated test ramp selected by i_test_sel.
module dsp_frame_gen #(
    parameter int PRI_LEN   = 4000,
    parameter int SMP_START = 100,
    parameter int SMP_LEN   = 2048,
    parameter int CHIRP_NUM = 32,
    parameter int DW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_enable,
    input  logic          i_test_sel,
    input  logic          i_adc_valid,
    input  logic [DW-1:0] i_adc_data,
    output logic          o_cpib,
    output logic          o_cpie,
    output logic          o_pri,
    output logic          o_smp_gate,
    output logic          o_tvalid,
    output logic [DW-1:0] o_tdata,
    output logic          o_busy,
    output logic          o_underrun,
    output logic [15:0]   o_frame_cnt
);
    localparam int PW = $clog2(PRI_LEN + 1);
    localparam int CW = $clog2(CHIRP_NUM + 1);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [PW-1:0] PRI_LAST = PW'(PRI_LEN - 1);
    localparam logic [PW-1:0] G_OPEN   = PW'(SMP_START);
    localparam logic [PW-1:0] G_CLOSE  = PW'(SMP_START + SMP_LEN);
    localparam logic [CW-1:0] CH_LAST  = CW'(CHIRP_NUM - 1);

    if (SMP_START + SMP_LEN > PRI_LEN) begin : g_chk_gate
        $error("dsp_frame_gen: SMP_START+SMP_LEN exceeds PRI_LEN");
    end
    if (PRI_LEN < 4 || CHIRP_NUM < 1) begin : g_chk_len
        $error("dsp_frame_gen: PRI_LEN must be >= 4 and CHIRP_NUM >= 1");
    end

    logic          state;
    logic [PW-1:0] pri_cnt;
    logic [CW-1:0] chirp_cnt;
    logic          run, pri_end, cpi_end, gate, tvalid_d, miss;
    logic [DW-1:0] tdata_d;

    always_comb begin
        run     = state == ST_RUN;
        pri_end = run && pri_cnt == PRI_LAST;
        cpi_end = pri_end && chirp_cnt == CH_LAST;
        gate    = run && pri_cnt >= G_OPEN && pri_cnt < G_CLOSE;
        miss    = o_smp_gate && !o_tvalid;
    end

`ifdef DSP_FRAME_TEST_PATTERN_EN
    // Ramp is the offset into the gate, so it restarts at 0 every PRI without extra state.
    always_comb begin
        tvalid_d = gate && (i_test_sel || i_adc_valid);
        tdata_d  = i_test_sel ? DW'(pri_cnt - G_OPEN) : i_adc_data;
    end
`else
    logic unused_test_sel;
    assign unused_test_sel = i_test_sel;
    always_comb begin
        tvalid_d = gate && i_adc_valid;
        tdata_d  = i_adc_data;
    end
`endif

    // Counters idle at zero, so leaving IDLE needs no separate initialisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pri_cnt     <= '0;
            chirp_cnt   <= '0;
            o_cpib      <= 1'b0;
            o_cpie      <= 1'b0;
            o_pri       <= 1'b0;
            o_smp_gate  <= 1'b0;
            o_tvalid    <= 1'b0;
            o_tdata     <= '0;
            o_busy      <= 1'b0;
            o_underrun  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            state       <= run ? !(cpi_end && !i_enable) : i_enable;
            pri_cnt     <= (run && !pri_end) ? pri_cnt + 1'b1 : '0;
            chirp_cnt   <= (!run || cpi_end) ? '0 : pri_end ? chirp_cnt + 1'b1 : chirp_cnt;
            o_pri       <= run && pri_cnt == '0;
            o_cpib      <= run && pri_cnt == '0 && chirp_cnt == '0;
            o_cpie      <= cpi_end;
            o_smp_gate  <= gate;
            o_tvalid    <= tvalid_d;
            o_tdata     <= tvalid_d ? tdata_d : o_tdata;
            o_busy      <= run;
            o_underrun  <= (o_underrun && !o_cpib) || miss;
            o_frame_cnt <= o_frame_cnt + 16'(o_cpie);
        end
    end
endmodule

// File: tb/tb_dsp_frame_gen.sv
// tb_dsp_frame_gen: directed checks of frame timing, gating, underrun, stop and reset behaviour.
module tb_dsp_frame_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_test_sel = 1'b0;
    logic        i_adc_valid = 1'b0;
    logic [15:0] i_adc_data = '0;
    logic        o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_busy, o_underrun;
    logic [15:0] o_tdata, o_frame_cnt;
    int n = 0;
    int k = 0;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dsp_frame_gen #(.PRI_LEN(64), .SMP_START(8), .SMP_LEN(32), .CHIRP_NUM(4), .DW(16)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_test_sel(i_test_sel),
        .i_adc_valid(i_adc_valid), .i_adc_data(i_adc_data),
        .o_cpib(o_cpib), .o_cpie(o_cpie), .o_pri(o_pri), .o_smp_gate(o_smp_gate),
        .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_busy(o_busy),
        .o_underrun(o_underrun), .o_frame_cnt(o_frame_cnt)
    );

    // Data input carries the step count, so a sample taken at an edge equals n-1 afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        n++;
        k++;
        i_adc_data = 16'(n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_busy, o_underrun} !== 7'd0)
            $display("FAIL reset_flags: got %b want 0000000", {o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_busy, o_underrun});
        else passed++;
        checks++;
        if (o_tdata !== 16'd0) $display("FAIL reset_tdata: got %0d want 0", o_tdata); else passed++;
        checks++;
        if (o_frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", o_frame_cnt); else passed++;
    endtask

    task automatic test_frame();
        int bad = 0, bad_d = 0, nvalid = 0, ph;
        logic ep, eb, ee, eg, ebusy;
        rst = 1'b0;
        i_enable = 1'b1;
        i_adc_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 258; i++) begin
            step();
            ph = k - 2;
            ep = k >= 2 && ph % 64 == 0;
            eb = k >= 2 && ph % 256 == 0;
            ee = k >= 2 && ph % 256 == 255;
            eg = k >= 2 && ph % 64 >= 8 && ph % 64 < 40;
            ebusy = k >= 2;
            if ({o_pri, o_cpib, o_cpie, o_smp_gate, o_tvalid, o_busy} !== {ep, eb, ee, eg, eg, ebusy}) bad++;
            if (o_tvalid && o_tdata !== 16'(n - 1)) bad_d++;
            if (k < 66 && o_tvalid) nvalid++;
            if (k == 2) begin
                checks++;
                if ({o_cpib, o_pri} !== 2'b11) $display("FAIL first_cpib: got %b want 11", {o_cpib, o_pri}); else passed++;
            end
            if (k == 257) begin
                checks++;
                if (o_cpie !== 1'b1) $display("FAIL cpie_at_257: got %b want 1", o_cpie); else passed++;
            end
            if (k == 258) begin
                checks++;
                if (o_frame_cnt !== 16'd1) $display("FAIL frame_cnt_1: got %0d want 1", o_frame_cnt); else passed++;
                checks++;
                if (o_cpib !== 1'b1) $display("FAIL back_to_back_cpib: got %b want 1", o_cpib); else passed++;
            end
        end
        checks++;
        if (bad !== 0) $display("FAIL frame_timing: got %0d bad cycles want 0", bad); else passed++;
        checks++;
        if (bad_d !== 0) $display("FAIL tdata_align: got %0d bad samples want 0", bad_d); else passed++;
        checks++;
        if (nvalid !== 32) $display("FAIL tvalid_per_pri: got %0d want 32", nvalid); else passed++;
    endtask

    task automatic test_stop();
        int npri = int'(o_pri), ncpie = 0;
        while (k < 520) begin
            step();
            if (k == 330) i_enable = 1'b0;
            npri += int'(o_pri);
            ncpie += int'(o_cpie);
            if (k == 513) begin
                checks++;
                if ({o_cpie, o_busy} !== 2'b11) $display("FAIL stop_cpie: got %b want 11", {o_cpie, o_busy}); else passed++;
            end
            if (k == 514) begin
                checks++;
                if ({o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_busy} !== 6'd0)
                    $display("FAIL stop_idle: got %b want 000000", {o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_busy});
                else passed++;
                checks++;
                if (o_frame_cnt !== 16'd2) $display("FAIL stop_frame_cnt: got %0d want 2", o_frame_cnt); else passed++;
            end
        end
        checks++;
        if (npri !== 4) $display("FAIL stop_pri_count: got %0d want 4", npri); else passed++;
        checks++;
        if (ncpie !== 1) $display("FAIL stop_cpie_count: got %0d want 1", ncpie); else passed++;
    endtask

    task automatic test_underrun();
        int nvalid = 0;
        i_enable = 1'b1;
        k = 0;
        for (int i = 0; i < 260; i++) begin
            step();
            if (k >= 2 && k < 66 && o_tvalid) nvalid++;
            if (k == 19) i_adc_valid = 1'b0;
            if (k == 20) begin
                i_adc_valid = 1'b1;
                checks++;
                if ({o_smp_gate, o_tvalid, o_underrun} !== 3'b100)
                    $display("FAIL miss_cycle: got %b want 100", {o_smp_gate, o_tvalid, o_underrun});
                else passed++;
            end
            if (k == 21) begin
                checks++;
                if (o_underrun !== 1'b1) $display("FAIL underrun_set: got %b want 1", o_underrun); else passed++;
            end
            if (k == 257) begin
                checks++;
                if (o_underrun !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", o_underrun); else passed++;
            end
            if (k == 259) begin
                checks++;
                if (o_underrun !== 1'b0) $display("FAIL underrun_clear: got %b want 0", o_underrun); else passed++;
            end
        end
        checks++;
        if (nvalid !== 31) $display("FAIL underrun_valid_count: got %0d want 31", nvalid); else passed++;
    endtask

    task automatic test_rst_mid_cpi();
        int ncpie = 0, nbusy = 0;
        while (k < 400) step();
        checks++;
        if (o_busy !== 1'b1) $display("FAIL pre_rst_busy: got %b want 1", o_busy); else passed++;
        rst = 1'b1;
        step();
        checks++;
        if ({o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_busy, o_underrun} !== 7'd0)
            $display("FAIL rst_flags: got %b want 0000000", {o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_busy, o_underrun});
        else passed++;
        checks++;
        if ({o_tdata, o_frame_cnt} !== 32'd0) $display("FAIL rst_data_cnt: got %h want 0", {o_tdata, o_frame_cnt}); else passed++;
        rst = 1'b0;
        i_enable = 1'b0;
        repeat (300) begin
            step();
            ncpie += int'(o_cpie);
            nbusy += int'(o_busy);
        end
        checks++;
        if ({ncpie, nbusy} !== 64'd0) $display("FAIL rst_no_cpie: got cpie=%0d busy=%0d want 0", ncpie, nbusy); else passed++;
    endtask

`ifdef DSP_FRAME_TEST_PATTERN_EN
    task automatic test_pattern();
        int bad = 0, ph;
        logic ev;
        i_enable = 1'b1;
        i_test_sel = 1'b1;
        i_adc_valid = 1'b0;
        k = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            ph = k - 2;
            ev = k >= 2 && ph % 64 >= 8 && ph % 64 < 40;
            if (o_tvalid !== ev || o_underrun !== 1'b0) bad++;
            if (ev && o_tdata !== 16'(ph % 64 - 8)) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL test_ramp: got %0d bad cycles want 0", bad); else passed++;
        i_enable = 1'b0;
        i_test_sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_stop();
        test_underrun();
        test_rst_mid_cpi();
`ifdef DSP_FRAME_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
